// File: rtl/tube_readout_pkg.sv
// Shared types and constants for the tube readout sequencer and its
// packet serializer.
package tube_readout_pkg;

    // Event sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        SNAP   = 2'd2,
        SEND   = 2'd3
    } tube_state_e;

    // Width of one tube cycle count.
    localparam int TUBE_CNT_W = 8;

    // Packet header layout: sequence number, then hit mask, then counts.
    localparam int HDR_SEQ   = 0;
    localparam int HDR_MASK  = 1;
    localparam int HDR_BYTES = 2;

    // Byte index register width; covers packets of up to 8 tubes + header.
    localparam int IDX_W = 4;

endpackage

// File: rtl/tube_readout_serializer.sv
// Packet serializer: captures the tube snapshot, hit mask and sequence
// number on load, then streams them as bytes over a valid/ready link.
//
// Handshake: a byte transfers on every rising edge where out_valid_o and
// out_ready_i are both high. While out_valid_o is high and out_ready_i is
// low, out_data_o and out_last_o are held unchanged. out_valid_o never
// drops before the byte it qualifies has transferred.
module readout_serializer
    import tube_readout_pkg::*;
#(
    parameter int NUM_TUBES = 8
) (
    input  logic                            clk,
    input  logic                            clr,
    input  logic                            load_i,
    input  logic [NUM_TUBES*TUBE_CNT_W-1:0] snap_i,
    input  logic [7:0]                      mask_i,
    input  logic [7:0]                      seq_i,
    input  logic                            out_ready_i,
    output logic [7:0]                      out_data_o,
    output logic                            out_valid_o,
    output logic                            out_last_o,
    output logic                            done_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TUBES + HDR_BYTES - 1);

    // Shadow copy of every tube count, frozen for the duration of the packet.
    logic [NUM_TUBES-1:0][TUBE_CNT_W-1:0] shadow_q;
    logic [7:0]                           mask_q;
    logic [IDX_W-1:0]                     idx_q;
    logic [7:0]                           data_q;
    logic                                 valid_q;
    logic                                 last_q;

    logic                                 fire;
    logic [IDX_W-1:0]                     idx_d;
    logic [7:0]                           data_d;

    assign fire = valid_q && out_ready_i;

    // Select the byte that follows the one currently presented.
    always_comb begin
        idx_d  = idx_q + 1'b1;
        data_d = 8'h00;
        if (idx_d == IDX_W'(HDR_MASK)) begin
            data_d = mask_q;
        end
        for (int i = 0; i < NUM_TUBES; i++) begin
            if (idx_d == IDX_W'(i + HDR_BYTES)) begin
                data_d = shadow_q[i];
            end
        end
    end

    // Snapshot capture, byte index and registered output stage.
    always_ff @(posedge clk) begin
        if (clr) begin
            shadow_q <= '0;
            mask_q   <= 8'h00;
            idx_q    <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else if (load_i) begin
            // The sequence number is the first byte, so present it at once.
            shadow_q <= snap_i;
            mask_q   <= mask_i;
            idx_q    <= IDX_W'(HDR_SEQ);
            data_q   <= seq_i;
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
        end else if (fire) begin
            if (last_q) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                data_q  <= 8'h00;
                idx_q   <= '0;
            end else begin
                idx_q  <= idx_d;
                data_q <= data_d;
                last_q <= (idx_d == LAST_IDX);
            end
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign done_o      = fire && last_q;

endmodule

// File: rtl/tube_readout.sv
// Event sequencer for the tube array: on trigger, release the tube clear,
// open the latch gate for a fixed window, snapshot every tube count and
// hand the snapshot to the serializer for transmission to the host link.
module tube_readout
    import tube_readout_pkg::*;
#(
    parameter int NUM_TUBES     = 8,
    parameter int WINDOW_CYCLES = 200
) (
    input  logic                            clk,
    input  logic                            clr,
    input  logic                            trigger,
    input  logic [NUM_TUBES*TUBE_CNT_W-1:0] tube_data,
    output logic                            tube_clr,
    output logic                            gate_enable,
    output logic [7:0]                      out_data,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            trig_dropped,
    output tube_state_e                     state_dbg
);

    localparam logic [7:0] WIN_LAST  = 8'(WINDOW_CYCLES - 1);
    localparam logic [7:0] WIN_LIMIT = 8'(WINDOW_CYCLES);

    tube_state_e state_q;
    logic [7:0]  win_cnt_q;
    logic [7:0]  seq_q;
    logic        tube_clr_q;
    logic        gate_q;
    logic        busy_q;
    logic        drop_q;

    logic [7:0]  hit_mask_d;
    logic        snap_load;
    logic        ser_done;

    // A tube that fired stopped counting before the window closed, so its
    // count is strictly below the window length; unused mask bits stay 0.
    always_comb begin
        hit_mask_d = 8'h00;
        for (int i = 0; i < NUM_TUBES; i++) begin
            hit_mask_d[i] = (tube_data[TUBE_CNT_W*i +: TUBE_CNT_W] < WIN_LIMIT);
        end
    end

    assign snap_load = (state_q == SNAP);

    // Event sequencer with registered tube controls, busy and drop pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            win_cnt_q  <= 8'h00;
            seq_q      <= 8'h00;
            tube_clr_q <= 1'b1;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= trigger && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q    <= WINDOW;
                        win_cnt_q  <= 8'h00;
                        tube_clr_q <= 1'b0;
                        gate_q     <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                WINDOW: begin
                    if (win_cnt_q == WIN_LAST) begin
                        // Close the gate but keep counts uncleared for the snapshot.
                        state_q <= SNAP;
                        gate_q  <= 1'b0;
                    end else begin
                        win_cnt_q <= win_cnt_q + 8'd1;
                    end
                end
                SNAP: begin
                    state_q    <= SEND;
                    tube_clr_q <= 1'b1;
                end
                SEND: begin
                    if (ser_done) begin
                        state_q <= IDLE;
                        seq_q   <= seq_q + 8'd1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tube_clr_q <= 1'b1;
                    gate_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    readout_serializer #(
        .NUM_TUBES (NUM_TUBES)
    ) u_serializer (
        .clk         (clk),
        .clr         (clr),
        .load_i      (snap_load),
        .snap_i      (tube_data),
        .mask_i      (hit_mask_d),
        .seq_i       (seq_q),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_last_o  (out_last),
        .done_o      (ser_done)
    );

    assign tube_clr     = tube_clr_q;
    assign gate_enable  = gate_q;
    assign busy         = busy_q;
    assign trig_dropped = drop_q;
    assign state_dbg    = state_q;

endmodule

// File: doc/tube_readout.md
Name: tube_readout

Overview:
- Event sequencer and readout stage sitting directly downstream of the per-tube cycle counters.
- On an external trigger, it releases the tube clear, opens the latch gate for a fixed window, then snapshots every tube's 8-bit cycle count.
- It streams the snapshot out as a byte packet over a valid/ready interface to the host link.
- Between events it holds all tubes cleared.

Parameters:
- NUM_TUBES, 8, number of tube channels; legal range 1..8.
- WINDOW_CYCLES, 200, gate-open duration in clk cycles; legal range 1..254, so tube counters never wrap.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clr  input  1  synchronous, active-high reset.
- trigger  input  1  event request; sampled only in IDLE.
- tube_data  input  NUM_TUBES*8  concatenated tube counts; tube i occupies bits [8i+7:8i].
- tube_clr  output  1  clear to all tube counters and latches.
- gate_enable  output  1  latch gate enable to all tubes.
- out_data  output  8  packet byte.
- out_valid  output  1  out_data valid.
- out_last  output  1  marks final byte of the packet; qualified by out_valid.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
- busy  output  1  high in every state except IDLE.
- trig_dropped  output  1  one-cycle pulse when trigger is high outside IDLE.

Behaviour:
- Reset (clr=1 at an edge):
  - state=IDLE, tube_clr=1, gate_enable=0, out_valid=0, out_last=0, out_data=0, busy=0, trig_dropped=0, event sequence number=0.
  - Reset is legal in any state; it aborts any packet in flight with no partial completion.
- States:
  - IDLE: tube_clr=1, gate_enable=0. trigger=1 moves to WINDOW next cycle.
  - WINDOW: tube_clr=0, gate_enable=1. Window counter runs 0..WINDOW_CYCLES-1. After exactly WINDOW_CYCLES cycles in WINDOW, move to SNAP.
  - SNAP (1 cycle): tube_clr=0, gate_enable=0. Register all tube_data into a shadow array. Compute hit_mask[i] = (count_i < WINDOW_CYCLES); mask bits >= NUM_TUBES are 0. Move to SEND.
  - SEND: tube_clr=1, gate_enable=0. Emit bytes in this order: [0] seq, [1] hit_mask, [2..NUM_TUBES+1] count of tube 0..NUM_TUBES-1.
    - Packet length is NUM_TUBES+2 bytes.
    - out_valid=1 throughout SEND. Byte index advances only on out_valid && out_ready.
    - out_data and out_last stay stable while stalled.
    - out_last=1 on index NUM_TUBES+1.
    - The handshake on the last byte returns to IDLE and increments seq (8-bit, wraps 255->0).
- Outputs are registered; out_valid rises the cycle after SNAP.
- A non-hit tube reads exactly WINDOW_CYCLES in the snapshot. A tube hit on the k-th window cycle reads k-1 or less.
- Triggers:
  - trigger in WINDOW/SNAP/SEND is ignored and pulses trig_dropped for each such cycle.
  - trigger held high continuously re-arms immediately on return to IDLE: one IDLE cycle, then WINDOW.
- Minimum trigger-to-first-byte latency is WINDOW_CYCLES+2 cycles.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WINDOW, SNAP, SEND);
  - TUBE_CNT_W=8;
  - the header byte index constants HDR_SEQ=0 and HDR_MASK=1.
- One sub-module, readout_serializer, is natural. It takes the snapshot array, mask and seq, and owns the byte index, the out_* registers and the handshake. The FSM stays in tube_readout.

Test Plan:
- Basic event: NUM_TUBES=8, WINDOW_CYCLES=200, model tubes hit at cycles 10,50,…, tube 7 never hits.
  - Expected: packet 0x00, 0x7F, 9, 49, …, 200 (tube 7); out_last only on byte 9; seq=1 afterwards.
- Backpressure: toggle out_ready pseudo-randomly.
  - Expected: same 10 bytes in order, no duplicates or drops, out_data/out_last stable while stalled.
- Dropped trigger: pulse trigger 3 cycles during WINDOW.
  - Expected: trig_dropped high exactly 3 cycles; only one packet is produced.
- Reset mid-SEND: assert clr after byte 4 is accepted.
  - Expected: next cycle state=IDLE, out_valid=0, tube_clr=1; the next event's seq byte = 0x00.
- Seq wrap: run 257 events.
  - Expected: the 256th packet has seq 0xFF, the 257th has 0x00.
- Gate timing: trigger at cycle T.
  - Expected: gate_enable high on cycles T+1..T+WINDOW_CYCLES exactly; tube_clr low on exactly those cycles plus the SNAP cycle.
